pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 96, payload width in bits (instruction + address + PC+4 packed by the user).
REQ-002 Parameter FLUSH_ZERO, default 1, 1 = flush also clears stored payloads to zero, 0 = flush clears valid only.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  discard all held entries (branch or jump redirect).
REQ-006 Port in_valid  input  1  upstream presents a payload.
REQ-007 Port in_ready  output  1  stage can accept a payload this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port out_valid  output  1  out_data holds a live payload.
REQ-010 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port out_data  output  DATA_W  payload to downstream.
REQ-012 Port occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Transfers occur only on valid&ready at the same edge: input on in_valid&in_ready, output on out_valid&out_ready.
REQ-014 Storage: main register (drives out_data) plus one skid register.
REQ-015 FSM states: EMPTY (0 held), BUSY (main held), FULL (main + skid held).
REQ-016 in_ready is a registered output and is 1 exactly when the state is not FULL; there is no combinational path from out_ready to in_ready.
REQ-017 out_valid is 1 when the state is not EMPTY; occupancy is 0, 1 or 2 for EMPTY, BUSY or FULL.
REQ-018 EMPTY with in_valid: main <= in_data and the state goes to BUSY, giving 1-cycle latency in to out.
REQ-019 BUSY with in_valid and out_ready: main <= in_data and the state stays BUSY, giving full throughput.
REQ-020 BUSY with in_valid and not out_ready: skid <= in_data and the state goes to FULL.
REQ-021 BUSY with out_ready and not in_valid: the state goes to EMPTY and main is retained unchanged.
REQ-022 BUSY with neither in_valid nor out_ready: hold.
REQ-023 FULL with out_ready: main <= skid and the state goes to BUSY; in_data is ignored because in_ready is 0.
REQ-024 FULL without out_ready: hold, with in_ready remaining 0.
REQ-025 Payloads exit in strict arrival order; none is duplicated or lost except by flush or reset.
REQ-026 flush has priority over every handshake:
- The state goes to EMPTY next cycle.
- A payload offered in the flush cycle is dropped.
- An output consumed in the flush cycle counts as consumed.
REQ-027 When FLUSH_ZERO = 1, flush also writes 0 to main and skid; when FLUSH_ZERO = 0, the data registers hold their values.
REQ-028 in_ready is 1 in the cycle after a flush.
REQ-029 out_data is undefined to consumers while out_valid = 0, but with FLUSH_ZERO = 1 it shall read 0 after reset or flush.

Reset
REQ-030 Reset has priority over flush and handshakes.
REQ-031 After a reset edge: state EMPTY, main = 0, skid = 0, out_valid = 0, in_ready = 1, occupancy = 0.
REQ-032 A reset asserted mid-operation, including in FULL, discards both entries with the same result as REQ-031.

Structure
REQ-033 Package pipe_pkg shall hold typedef enum stage_state_e {EMPTY, BUSY, FULL} and localparam IF_ID_W = 96.
REQ-034 The block is a single module with no sub-module; skid and main are plain registers inside it.
REQ-035 Successor IF/ID, ID/EX and later stage registers instantiate pipe_stage_skid with the appropriate DATA_W.

Verification
REQ-036 Reset, then in_valid = 1 with in_data = 0xA and out_ready = 1 held -> out_valid = 1 with out_data = 0xA on the next cycle, and one output per cycle for a stream 0xA, 0xB, 0xC.
REQ-037 BUSY holding 0x1, in_data = 0x2, out_ready = 0 -> FULL, occupancy = 2, in_ready = 0; release out_ready -> outputs 0x1 then 0x2 on consecutive cycles.
REQ-038 FULL with flush = 1, FLUSH_ZERO = 1 -> next cycle out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0.
REQ-039 flush coinciding with in_valid = 1 carrying 0x5 -> 0x5 never appears at the output.
REQ-040 Reset asserted in FULL -> REQ-031 values next cycle; random valid/ready stress of 10k cycles checked against a queue model shows order preserved and no loss.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers built on pipe_stage_skid.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // IF/ID payload: instruction + address + PC+4
  localparam int IF_ID_W = 96;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage register with a registered in_ready
// and flush support for branch/jump redirects.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid;

  // In EMPTY/BUSY in_ready is 1, so in_valid alone means an input transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (in_valid) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          w_ld_main_in = 1'b1;
        end else if (in_valid) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = FULL;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      if (FLUSH_ZERO) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      // in_ready tracks the next state so it never depends on out_ready combinationally
      r_in_ready <= (w_state_nxt != FULL);
      if (w_ld_main_in)
        r_main <= in_data;
      else if (w_ld_main_skid)
        r_main <= r_skid;
      if (w_ld_skid)
        r_skid <= in_data;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, a
// FLUSH_ZERO=0 sequence, and randomized stress against a queue model.
module tb_pipe_stage_skid;

  localparam int W = 96;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic         nz_in_ready, nz_out_valid;
  logic [W-1:0] nz_out_data;
  logic [1:0]   nz_occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .FLUSH_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(W), .FLUSH_ZERO(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nz_in_ready), .in_data(in_data),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_data(nz_out_data),
    .occupancy(nz_occupancy)
  );

  typedef struct {
    logic         rst, fl, iv, ordy;
    logic [W-1:0] din;
    logic         ov, ir;
    logic [1:0]   occ;
    logic [W-1:0] od;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, fl, iv, input logic [W-1:0] din, input logic ordy,
                     input logic ov, ir, input logic [1:0] occ, input logic [W-1:0] od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.occ = occ; v.od = od;
    vt.push_back(v);
  endtask

  task automatic drive(input logic rst, fl, iv, input logic [W-1:0] din, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
  endtask

  // Reference model: a FIFO of at most two entries plus the last value shown on out_data.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_stale;

  task automatic model_edge();
    int sz;
    sz = mq.size();
    if (reset) begin
      mq.delete(); m_stale = '0;
    end else if (flush) begin
      mq.delete(); m_stale = '0;
    end else begin
      if (out_ready && sz > 0) begin
        if (sz == 1) m_stale = mq[0];
        void'(mq.pop_front());
      end
      if (in_valid && sz < 2) mq.push_back(in_data);
    end
  endtask

  initial begin
    logic [W-1:0] exp_od;
    int           sz;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    m_stale = '0;

    //  rst fl iv din         ordy  ov ir occ od
    add(1, 0, 0, 96'h0,       0,    0, 1, 0, 96'h0);
    add(0, 0, 1, 96'hA,       1,    1, 1, 1, 96'hA);
    add(0, 0, 1, 96'hB,       1,    1, 1, 1, 96'hB);
    add(0, 0, 1, 96'hC,       1,    1, 1, 1, 96'hC);
    add(0, 0, 0, 96'h0,       1,    0, 1, 0, 96'hC);
    add(0, 0, 1, 96'h1,       0,    1, 1, 1, 96'h1);
    add(0, 0, 1, 96'h2,       0,    1, 0, 2, 96'h1);
    add(0, 0, 1, 96'h3,       0,    1, 0, 2, 96'h1);
    add(0, 0, 0, 96'h0,       1,    1, 1, 1, 96'h2);
    add(0, 0, 0, 96'h0,       1,    0, 1, 0, 96'h2);
    add(0, 0, 1, 96'h4,       0,    1, 1, 1, 96'h4);
    add(0, 0, 1, 96'h6,       0,    1, 0, 2, 96'h4);
    add(0, 1, 0, 96'h0,       0,    0, 1, 0, 96'h0);
    add(0, 1, 1, 96'h5,       0,    0, 1, 0, 96'h0);
    add(0, 0, 0, 96'h0,       1,    0, 1, 0, 96'h0);
    add(0, 0, 1, 96'h7,       0,    1, 1, 1, 96'h7);
    add(0, 0, 1, 96'h8,       0,    1, 0, 2, 96'h7);
    add(1, 0, 1, 96'h9,       1,    0, 1, 0, 96'h0);
    add(0, 0, 1, 96'h1234,    0,    1, 1, 1, 96'h1234);
    add(0, 1, 0, 96'h0,       1,    0, 1, 0, 96'h0);
    add(0, 0, 1, 96'h55,      0,    1, 1, 1, 96'h55);
    add(0, 0, 0, 96'h0,       0,    1, 1, 1, 96'h55);
    add(1, 1, 1, 96'h66,      1,    0, 1, 0, 96'h0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].din, vt[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vt[i].ov));
      chk($sformatf("vec%0d in_ready", i),  W'(in_ready),  W'(vt[i].ir));
      chk($sformatf("vec%0d occupancy", i), W'(occupancy), W'(vt[i].occ));
      chk($sformatf("vec%0d out_data", i),  out_data,      vt[i].od);
    end

    // FLUSH_ZERO=0: flush clears valid but leaves main holding its payload
    drive(0, 0, 1, 96'h77, 0); @(posedge clk); #1;
    drive(0, 0, 1, 96'h78, 0); @(posedge clk); #1;
    chk("nz full occ", W'(nz_occupancy), W'(2'd2));
    drive(0, 1, 0, 96'h0, 0); @(posedge clk); #1;
    chk("nz flush valid",   W'(nz_out_valid), W'(1'b0));
    chk("nz flush ready",   W'(nz_in_ready),  W'(1'b1));
    chk("nz flush data",    nz_out_data,      96'h77);
    chk("fz flush data",    out_data,         96'h0);
    drive(1, 0, 0, 96'h0, 0); @(posedge clk); #1;
    chk("nz reset data",    nz_out_data,      96'h0);

    // randomized stress against the queue model
    mq.delete(); m_stale = '0;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
            ($urandom_range(0, 2) != 0));
      @(posedge clk);
      model_edge();
      #1;
      sz = mq.size();
      exp_od = (sz > 0) ? mq[0] : m_stale;
      n_tests++;
      if (out_valid !== (sz > 0) || in_ready !== (sz < 2) ||
          occupancy !== 2'(sz) || out_data !== exp_od) begin
        n_fail++;
        $display("FAIL rand cyc%0d: got v=%0b r=%0b occ=%0d d=%0h expected v=%0b r=%0b occ=%0d d=%0h",
                 c, out_valid, in_ready, occupancy, out_data, (sz > 0), (sz < 2), sz, exp_od);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
